// File: rtl/ins_fetch_ctrl.sv
// ins_fetch_ctrl: arbitrates a shared byte memory between byte loads and 32-bit big-endian instruction fetches.
module ins_fetch_ctrl #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              FetchReq,
   input  logic [31:0]       FetchAddr,
   output logic              FetchAck,
   output logic              FetchBusy,
   output logic              InsValid,
   output logic [31:0]       Ins,
   output logic              AlignErr,
   input  logic              LoadReq,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [7:0]        LoadByte,
   output logic              LoadAck,
   output logic [ADDR_W-1:0] MemAddr,
   output logic              MemWe,
   output logic [7:0]        MemWData,
   input  logic [7:0]        MemRData
);
   typedef enum logic [1:0] {IDLE, LOAD, FETCH, DRAIN} state_t;
   state_t state;
   logic [1:0] k;
   logic [ADDR_W-1:0] base, ld_addr;
   logic [7:0] ld_byte;
   logic [23:0] part;
   logic last_load;
   logic both, grant_load, grant_fetch;
   logic unused_addr;
   assign unused_addr = ^FetchAddr[31:ADDR_W];
   // On a tie the requester that did not win the previous tie is served.
   assign both        = FetchReq & LoadReq;
   assign grant_load  = LoadReq & (~FetchReq | ~last_load);
   assign grant_fetch = FetchReq & ~grant_load;
   assign MemAddr   = state == FETCH ? base + ADDR_W'(k) : state == LOAD ? ld_addr : '0;
   assign MemWe     = state == LOAD;
   assign MemWData  = state == LOAD ? ld_byte : '0;
   assign FetchBusy = state == FETCH || state == DRAIN;
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= IDLE;
         k         <= '0;
         base      <= '0;
         ld_addr   <= '0;
         ld_byte   <= '0;
         part      <= '0;
         last_load <= 1'b0;
         Ins       <= '0;
         InsValid  <= 1'b0;
         FetchAck  <= 1'b0;
         LoadAck   <= 1'b0;
         AlignErr  <= 1'b0;
      end else begin
         InsValid <= 1'b0;
         FetchAck <= 1'b0;
         LoadAck  <= 1'b0;
         AlignErr <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_load) begin
                  state   <= LOAD;
                  ld_addr <= LoadAddr;
                  ld_byte <= LoadByte;
                  LoadAck <= 1'b1;
                  if (both) last_load <= 1'b1;
               end else if (grant_fetch) begin
                  FetchAck <= 1'b1;
                  if (both) last_load <= 1'b0;
                  if (FetchAddr[1:0] != 2'b00) AlignErr <= 1'b1;
                  else begin
                     state <= FETCH;
                     base  <= FetchAddr[ADDR_W-1:0];
                     k     <= '0;
                  end
               end
            end
            LOAD: state <= IDLE;
            FETCH: begin
               // read data lags the address by one cycle, so bytes arrive in order and shift in
               if (k != 2'd0) part <= {part[15:0], MemRData};
               k <= k + 2'd1;
               if (k == 2'd3) state <= DRAIN;
            end
            DRAIN: begin
               Ins      <= {part, MemRData};
               InsValid <= 1'b1;
               k        <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// tb_ins_fetch_ctrl: directed checks of arbitration, fetch assembly, alignment, wrap and reset abort.
module tb_ins_fetch_ctrl;
   logic clk = 1'b0;
   logic Reset = 1'b1;
   logic FetchReq = 1'b0;
   logic [31:0] FetchAddr = '0;
   logic FetchAck, FetchBusy, InsValid, AlignErr, LoadAck, MemWe;
   logic [31:0] Ins;
   logic LoadReq = 1'b0;
   logic [6:0] LoadAddr = '0;
   logic [7:0] LoadByte = '0;
   logic [6:0] MemAddr;
   logic [7:0] MemWData;
   logic [7:0] MemRData;
   logic [7:0] mem [128];
   int total = 0;
   int bad = 0;
   logic [31:0] cur_ins = '0;

   ins_fetch_ctrl #(.ADDR_W(7)) dut (
      .clk(clk), .Reset(Reset),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck), .FetchBusy(FetchBusy),
      .InsValid(InsValid), .Ins(Ins), .AlignErr(AlignErr),
      .LoadReq(LoadReq), .LoadAddr(LoadAddr), .LoadByte(LoadByte), .LoadAck(LoadAck),
      .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (MemWe) mem[MemAddr] <= MemWData;
      MemRData <= mem[MemAddr];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic do_load(input logic [6:0] a, input logic [7:0] b);
      LoadReq = 1'b1; LoadAddr = a; LoadByte = b;
      @(negedge clk);
      chk("load_ack", 32'(LoadAck), 1);
      chk("load_we", 32'(MemWe), 1);
      chk("load_addr", 32'(MemAddr), 32'(a));
      chk("load_data", 32'(MemWData), 32'(b));
      LoadReq = 1'b0;
      @(negedge clk);
      chk("load_we_off", 32'(MemWe), 0);
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp);
      FetchReq = 1'b1; FetchAddr = a;
      @(negedge clk);
      chk("fetch_ack", 32'(FetchAck), 1);
      chk("fetch_align", 32'(AlignErr), 0);
      FetchReq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            chk("fetch_ack_once", 32'(FetchAck), 0);
         end
         chk("fetch_addr", 32'(MemAddr), (a + 32'(i)) % 128);
         chk("fetch_busy", 32'(FetchBusy), 1);
         chk("fetch_we", 32'(MemWe), 0);
         chk("fetch_ins_hold", Ins, cur_ins);
      end
      @(negedge clk);
      chk("drain_busy", 32'(FetchBusy), 1);
      chk("drain_addr", 32'(MemAddr), 0);
      chk("drain_valid", 32'(InsValid), 0);
      chk("drain_ins_hold", Ins, cur_ins);
      @(negedge clk);
      chk("ins_valid", 32'(InsValid), 1);
      chk("ins", Ins, exp);
      chk("done_busy", 32'(FetchBusy), 0);
      cur_ins = exp;
   endtask

   task automatic do_misalign(input logic [31:0] a);
      FetchReq = 1'b1; FetchAddr = a;
      @(negedge clk);
      chk("mis_ack", 32'(FetchAck), 1);
      chk("mis_err", 32'(AlignErr), 1);
      chk("mis_busy", 32'(FetchBusy), 0);
      chk("mis_we", 32'(MemWe), 0);
      chk("mis_valid", 32'(InsValid), 0);
      chk("mis_ins", Ins, cur_ins);
      FetchReq = 1'b0;
      @(negedge clk);
      chk("mis_ack_once", 32'(FetchAck), 0);
      chk("mis_err_once", 32'(AlignErr), 0);
      chk("mis_busy_after", 32'(FetchBusy), 0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ins", Ins, 0);
      chk("rst_addr", 32'(MemAddr), 0);
      chk("rst_we", 32'(MemWe), 0);
      chk("rst_wdata", 32'(MemWData), 0);
      chk("rst_busy", 32'(FetchBusy), 0);
      chk("rst_acks", {29'd0, FetchAck, LoadAck, AlignErr}, 0);
      chk("rst_valid", 32'(InsValid), 0);
      Reset = 1'b0;
      do_load(7'd0, 8'h8C);
      do_load(7'd1, 8'h01);
      do_load(7'd2, 8'h00);
      do_load(7'd3, 8'h04);
      do_load(7'd124, 8'h12);
      do_load(7'd125, 8'h34);
      do_load(7'd126, 8'h56);
      do_load(7'd127, 8'h78);
      do_fetch(32'd0, 32'h8C010004);
      // first tie after reset goes to the load
      FetchReq = 1'b1; FetchAddr = 32'd0;
      LoadReq = 1'b1; LoadAddr = 7'd5; LoadByte = 8'hAA;
      @(negedge clk);
      chk("tie1_load_ack", 32'(LoadAck), 1);
      chk("tie1_fetch_ack", 32'(FetchAck), 0);
      chk("tie1_we", 32'(MemWe), 1);
      chk("tie1_addr", 32'(MemAddr), 5);
      chk("tie1_data", 32'(MemWData), 32'h0AA);
      LoadReq = 1'b0;
      @(negedge clk);
      chk("tie1_gap_ack", 32'(FetchAck), 0);
      chk("tie1_gap_we", 32'(MemWe), 0);
      do_fetch(32'd0, 32'h8C010004);
      // second tie goes to the fetch; the waiting load follows in the InsValid cycle
      LoadReq = 1'b1; LoadAddr = 7'd9; LoadByte = 8'h55;
      do_fetch(32'd0, 32'h8C010004);
      chk("tie2_load_wait", 32'(LoadAck), 0);
      @(negedge clk);
      chk("tie2_load_ack", 32'(LoadAck), 1);
      chk("tie2_we", 32'(MemWe), 1);
      chk("tie2_addr", 32'(MemAddr), 9);
      LoadReq = 1'b0;
      @(negedge clk);
      chk("mem5", 32'(mem[5]), 32'h0AA);
      chk("mem9", 32'(mem[9]), 32'h055);
      do_misalign(32'd2);
      do_fetch(32'd124, 32'h12345678);
      do_misalign(32'd126);
      // abort a fetch with reset in its second FETCH cycle
      FetchReq = 1'b1; FetchAddr = 32'd0;
      @(negedge clk);
      chk("abort_ack", 32'(FetchAck), 1);
      FetchReq = 1'b0;
      @(negedge clk);
      chk("abort_addr", 32'(MemAddr), 1);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      chk("abort_ins", Ins, 0);
      chk("abort_busy", 32'(FetchBusy), 0);
      chk("abort_addr0", 32'(MemAddr), 0);
      cur_ins = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 32'(InsValid), 0);
         chk("abort_idle", 32'(FetchBusy), 0);
      end
      do_fetch(32'd0, 32'h8C010004);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
